// File: rtl/wb_regbank.sv
// Four-entry 8-bit writeback register bank with same-cycle bypass and a pending-write scoreboard.
// Optional feature macro: WB_REGBANK_R0ZERO_EN (register 0 hardwired to zero).
module wb_regbank #(
    parameter int         NREG     = 4,
    parameter logic [1:0] PEND_MAX = 2'd3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       WR,
    input  logic [1:0] rd,
    input  logic [7:0] data,
    input  logic       issue_valid,
    input  logic       issue_wr,
    input  logic [1:0] issue_rd,
    input  logic [1:0] rs1,
    input  logic [1:0] rs2,
    output logic [7:0] rdata1,
    output logic [7:0] rdata2,
    output logic       hazard1,
    output logic       hazard2,
    output logic       sb_err
);

`ifdef WB_REGBANK_R0ZERO_EN
    localparam logic R0ZERO = 1'b1;
`else
    localparam logic R0ZERO = 1'b0;
`endif

    logic [7:0]      regs_r     [NREG];
    logic [1:0]      pend_r     [NREG];
    logic [1:0]      pend_nxt_s [NREG];
    logic [NREG-1:0] inc_s;
    logic [NREG-1:0] dec_s;
    logic            err_s;
    logic            sb_err_r;
    logic            wr_ok_s;

    // Writes that actually land in storage (index 0 is dropped when hardwired).
    always_comb begin
        wr_ok_s = WR & ~(R0ZERO & (rd == 2'd0));
    end

    // Read ports with bypass of the writeback landing this cycle.
    always_comb begin
        if (wr_ok_s && (rd == rs1)) begin
            rdata1 = data;
        end else begin
            rdata1 = regs_r[rs1];
        end
        if (wr_ok_s && (rd == rs2)) begin
            rdata2 = data;
        end else begin
            rdata2 = regs_r[rs2];
        end
    end

    // A landing write only clears the hazard when it is the last outstanding one.
    always_comb begin
        hazard1 = (pend_r[rs1] != 2'd0) & ~(WR & (rd == rs1) & (pend_r[rs1] == 2'd1));
        hazard2 = (pend_r[rs2] != 2'd0) & ~(WR & (rd == rs2) & (pend_r[rs2] == 2'd1));
    end

    // Pending-counter next state with saturation; over/underflow flags an error.
    always_comb begin
        inc_s = '0;
        dec_s = '0;
        err_s = 1'b0;
        for (int i = 0; i < NREG; i++) begin
            pend_nxt_s[i] = pend_r[i];
            inc_s[i] = issue_valid & issue_wr & (issue_rd == 2'(i)) & ~(R0ZERO & (i == 0));
            dec_s[i] = WR & (rd == 2'(i)) & ~(R0ZERO & (i == 0));
            case ({inc_s[i], dec_s[i]})
                2'b10: begin
                    if (pend_r[i] == PEND_MAX) begin
                        err_s = 1'b1;
                    end else begin
                        pend_nxt_s[i] = pend_r[i] + 2'd1;
                    end
                end
                2'b01: begin
                    if (pend_r[i] == 2'd0) begin
                        err_s = 1'b1;
                    end else begin
                        pend_nxt_s[i] = pend_r[i] - 2'd1;
                    end
                end
                default: pend_nxt_s[i] = pend_r[i];
            endcase
        end
    end

    // State update; reset discards any writeback or issue on the same edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                regs_r[i] <= 8'h00;
                pend_r[i] <= 2'd0;
            end
            sb_err_r <= 1'b0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                if (wr_ok_s && (rd == 2'(i))) begin
                    regs_r[i] <= data;
                end
                pend_r[i] <= pend_nxt_s[i];
            end
            sb_err_r <= sb_err_r | err_s;
        end
    end

    assign sb_err = sb_err_r;

endmodule

// File: tb/tb_wb_regbank.sv
// Scoreboard-driven bench for wb_regbank: expectations are queued as stimulus is driven
// and compared against captured outputs at the end of each scenario.
module tb_wb_regbank;

`ifdef WB_REGBANK_R0ZERO_EN
    localparam bit R0Z = 1'b1;
`else
    localparam bit R0Z = 1'b0;
`endif

    localparam int K_R1 = 0;
    localparam int K_R2 = 1;
    localparam int K_H1 = 2;
    localparam int K_H2 = 3;
    localparam int K_ERR = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       WR = 1'b0;
    logic [1:0] rd = 2'd0;
    logic [7:0] data = 8'h00;
    logic       issue_valid = 1'b0;
    logic       issue_wr = 1'b0;
    logic [1:0] issue_rd = 2'd0;
    logic [1:0] rs1 = 2'd0;
    logic [1:0] rs2 = 2'd0;
    logic [7:0] rdata1, rdata2;
    logic       hazard1, hazard2, sb_err;

    int total = 0;
    int bad = 0;

    typedef struct {
        string      name;
        int         kind;
        logic [7:0] val;
    } exp_t;

    exp_t       exp_q[$];
    logic [7:0] act_q[$];

    wb_regbank dut (
        .clk(clk), .rst_n(rst_n), .WR(WR), .rd(rd), .data(data),
        .issue_valid(issue_valid), .issue_wr(issue_wr), .issue_rd(issue_rd),
        .rs1(rs1), .rs2(rs2), .rdata1(rdata1), .rdata2(rdata2),
        .hazard1(hazard1), .hazard2(hazard2), .sb_err(sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] obs(int k);
        case (k)
            K_R1:    return rdata1;
            K_R2:    return rdata2;
            K_H1:    return {7'd0, hazard1};
            K_H2:    return {7'd0, hazard2};
            K_ERR:   return {7'd0, sb_err};
            default: return 8'hxx;
        endcase
    endfunction

    task automatic push(string n, int k, logic [7:0] v);
        exp_t e;
        e.name = n;
        e.kind = k;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    // Capture DUT outputs for every expectation queued since the last capture.
    task automatic sample();
        while (act_q.size() < exp_q.size()) begin
            act_q.push_back(obs(exp_q[act_q.size()].kind));
        end
    endtask

    // Inputs change on the falling edge; outputs are captured 1 time unit later.
    task automatic step(logic wr_i, logic [1:0] rd_i, logic [7:0] d_i,
                        logic iv_i, logic [1:0] ird_i, logic [1:0] s1, logic [1:0] s2);
        @(negedge clk);
        WR = wr_i; rd = rd_i; data = d_i;
        issue_valid = iv_i; issue_wr = iv_i; issue_rd = ird_i;
        rs1 = s1; rs2 = s2;
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        WR = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        exp_t e; logic [7:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'(i), 2'(3 - i));
            push($sformatf("reset_rdata1_%0d", i), K_R1, 8'h00);
            push($sformatf("reset_rdata2_%0d", i), K_R2, 8'h00);
            push($sformatf("reset_haz1_%0d", i), K_H1, 8'h00);
            push($sformatf("reset_haz2_%0d", i), K_H2, 8'h00);
            push($sformatf("reset_sberr_%0d", i), K_ERR, 8'h00);
            sample();
        end
        step(1'b1, 2'd2, 8'hA5, 1'b0, 2'd0, 2'd0, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd0);
        push("write_then_read", K_R1, 8'hA5);
        push("write_other_untouched", K_R2, 8'h00);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_bypass();
        exp_t e; logic [7:0] a;
        step(1'b1, 2'd1, 8'h3C, 1'b0, 2'd0, 2'd1, 2'd1);
        push("bypass_rdata1", K_R1, 8'h3C);
        push("bypass_rdata2", K_R2, 8'h3C);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd1, 2'd2);
        push("bypass_committed", K_R1, 8'h3C);
        push("bypass_reg2_kept", K_R2, 8'hA5);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_raw();
        exp_t e; logic [7:0] a;
        do_reset();
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd0);
        push("raw_issue_no_haz_yet", K_H1, 8'h00);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd3, 2'd3, 2'd0);
        push("raw_pend1_haz", K_H1, 8'h01);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd0);
        push("raw_pend2_haz", K_H1, 8'h01);
        sample();
        step(1'b1, 2'd3, 8'h11, 1'b0, 2'd0, 2'd3, 2'd0);
        push("raw_first_wb_haz", K_H1, 8'h01);
        push("raw_first_wb_data", K_R1, 8'h11);
        sample();
        step(1'b1, 2'd3, 8'h22, 1'b0, 2'd0, 2'd3, 2'd0);
        push("raw_last_wb_haz", K_H1, 8'h00);
        push("raw_last_wb_data", K_R1, 8'h22);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd3);
        push("raw_after_haz1", K_H1, 8'h00);
        push("raw_after_haz2", K_H2, 8'h00);
        push("raw_after_data", K_R2, 8'h22);
        push("raw_no_err", K_ERR, 8'h00);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_same_cycle();
        exp_t e; logic [7:0] a;
        do_reset();
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd2, 2'd2, 2'd0);
        step(1'b1, 2'd2, 8'h44, 1'b1, 2'd2, 2'd2, 2'd0);
        push("same_landing_haz", K_H1, 8'h00);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd0);
        push("same_pend_kept_haz", K_H1, 8'h01);
        push("same_data", K_R1, 8'h44);
        push("same_no_err", K_ERR, 8'h00);
        sample();
        step(1'b1, 2'd2, 8'h55, 1'b0, 2'd0, 2'd2, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd0);
        push("same_drained_haz", K_H1, 8'h00);
        push("same_drained_err", K_ERR, 8'h00);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_overflow();
        exp_t e; logic [7:0] a;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 2'd0, 8'h00, 1'b1, 2'd1, 2'd0, 2'd1);
            push($sformatf("ovf_no_err_%0d", i), K_ERR, 8'h00);
            sample();
        end
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd1);
        push("ovf_err_set", K_ERR, 8'h01);
        push("ovf_haz", K_H2, 8'h01);
        sample();
        step(1'b1, 2'd1, 8'h61, 1'b0, 2'd0, 2'd0, 2'd1);
        step(1'b1, 2'd1, 8'h62, 1'b0, 2'd0, 2'd0, 2'd1);
        push("ovf_saturated_haz", K_H2, 8'h01);
        sample();
        step(1'b1, 2'd1, 8'h63, 1'b0, 2'd0, 2'd0, 2'd1);
        push("ovf_last_wb_haz", K_H2, 8'h00);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd1);
        push("ovf_err_sticky", K_ERR, 8'h01);
        push("ovf_final_data", K_R2, 8'h63);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_underflow_r0();
        exp_t e; logic [7:0] a;
        do_reset();
        step(1'b1, 2'd0, 8'h5A, 1'b0, 2'd0, 2'd0, 2'd0);
        push("r0_wb_bypass", K_R1, R0Z ? 8'h00 : 8'h5A);
        push("r0_wb_haz", K_H1, 8'h00);
        push("r0_wb_err_before", K_ERR, 8'h00);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
        push("r0_reg_value", K_R1, R0Z ? 8'h00 : 8'h5A);
        push("r0_underflow_err", K_ERR, R0Z ? 8'h00 : 8'h01);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b1, 2'd0, 2'd0, 2'd0);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd0, 2'd0);
        push("r0_issue_haz", K_H1, R0Z ? 8'h00 : 8'h01);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    task automatic test_reset_midop();
        exp_t e; logic [7:0] a;
        do_reset();
        step(1'b1, 2'd3, 8'h77, 1'b1, 2'd1, 2'd3, 2'd1);
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd3, 2'd1);
        push("mid_pre_data", K_R1, 8'h77);
        push("mid_pre_haz", K_H2, 8'h01);
        push("mid_pre_err", K_ERR, 8'h01);
        sample();
        @(negedge clk);
        rst_n = 1'b0;
        WR = 1'b1; rd = 2'd1; data = 8'h99;
        issue_valid = 1'b1; issue_wr = 1'b1; issue_rd = 2'd2;
        @(negedge clk);
        rst_n = 1'b1;
        WR = 1'b0; issue_valid = 1'b0; issue_wr = 1'b0;
        rs1 = 2'd3; rs2 = 2'd1;
        #1;
        push("mid_reg3_cleared", K_R1, 8'h00);
        push("mid_wb_discarded", K_R2, 8'h00);
        push("mid_pend1_cleared", K_H2, 8'h00);
        push("mid_err_cleared", K_ERR, 8'h00);
        sample();
        step(1'b0, 2'd0, 8'h00, 1'b0, 2'd0, 2'd2, 2'd2);
        push("mid_issue_discarded", K_H1, 8'h00);
        sample();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front(); a = act_q.pop_front(); total++;
            if (a !== e.val) begin bad++; $display("FAIL %s: got %h expected %h", e.name, a, e.val); end
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_raw();
        test_same_cycle();
        test_overflow();
        test_underflow_r0();
        test_reset_midop();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
